hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage data path. It generates the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline buffers. It resolves three conditions:
- load-use hazards, by inserting one bubble;
- taken-branch redirects, by flushing two stages;
- multi-cycle data-memory waits, by freezing the whole pipeline.

It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

## Interface
Parameters:
- REG_W, 5, register-address width
- CNT_W, 32, width of statistics counters
- TIMEOUT, 16, consecutive mem_busy cycles before mem_timeout_o is raised (min 1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_rs_i  in  REG_W  rs field of instruction in IF/ID
- id_rt_i  in  REG_W  rt field of instruction in IF/ID
- id_uses_rt_i  in  1  instruction in IF/ID reads rt
- ex_mem_read_i  in  1  instruction in ID/EX is a load
- ex_rd_i  in  REG_W  destination register of instruction in ID/EX
- branch_taken_i  in  1  EX-stage redirect request
- mem_busy_i  in  1  data memory has not completed the current access
- pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o  out  1 each  buffer capture enables
- ifid_flush_o, idex_flush_o  out  1 each  synchronous clear of IF/ID and ID/EX on the next edge
- stall_cnt_o  out  CNT_W  cycles lost to stalls/freezes
- flush_cnt_o  out  CNT_W  branch flushes performed
- mem_timeout_o  out  1  sticky: memory wait exceeded TIMEOUT

## Operation
- State machine: RUN, FLUSH, MEM_WAIT (registered); state, wait counter, statistics and flag are updated on posedge clk.
- Enables and flushes are combinational from the current state and inputs.
- Each cycle the highest-priority active condition applies:
  1. **Freeze** (mem_busy_i=1):
     - all five enables 0, both flushes 0;
     - stall_cnt +1;
     - next state MEM_WAIT.
  2. **Redirect** (branch_taken_i=1):
     - all enables 1, ifid_flush_o=1, idex_flush_o=1;
     - flush_cnt +1;
     - next state FLUSH.
  3. **Load-use**:
     - Condition: ex_mem_read_i=1, ex_rd_i≠0, state≠FLUSH, and either ex_rd_i==id_rs_i or (id_uses_rt_i=1 and ex_rd_i==id_rt_i).
     - Response: pc_en_o=0, ifid_en_o=0, idex_en_o=1, idex_flush_o=1 (bubble), exmem_en_o=memwb_en_o=1.
     - stall_cnt +1; next state RUN.
  4. **Normal**: all enables 1, flushes 0, next state RUN.
- FLUSH lasts one cycle. Load-use detection is suppressed in FLUSH because IF/ID holds a cleared instruction.
- Register 0 never causes a hazard.
- Branch during a freeze: ignored while mem_busy_i=1. EX holds the branch because ID/EX is frozen, so the redirect is applied on the first cycle after busy drops.
- Branch in FLUSH state: flush again; remain in FLUSH.
- Watchdog:
  - wait_cnt increments on each consecutive busy cycle and clears when mem_busy_i=0.
  - mem_timeout_o sets on the edge that ends the TIMEOUT-th consecutive busy cycle.
  - Once set, it holds until reset.
  - It does not alter enables.
- Counters saturate at all-ones; no wrap-around.
- Mid-operation reset: pipeline state is discarded immediately; state goes to RUN.

## Timing
- While rst=0, asynchronously:
  - all enables 0, flushes 0;
  - stall_cnt_o=0, flush_cnt_o=0, mem_timeout_o=0;
  - state RUN, wait_cnt=0.
- First edge after rst rises: normal operation, with outputs computed from inputs in the same cycle.
- Zero-cycle latency from hazard inputs to enables/flushes (Mealy). Statistics and the flag update one edge later.
- Load-use costs exactly 1 cycle. On the next cycle the load is in EX/MEM and ex_mem_read_i sees the bubble (0).
- Redirect costs 2 squashed instructions. Flushes are applied on the same edge that loads the branch target into the PC.
- Freeze lasts exactly as long as mem_busy_i=1.

## Test plan
- **Load-use:** ex_mem_read_i=1, ex_rd_i=5, id_rs_i=5, no busy/branch → one cycle with pc_en_o=0, ifid_en_o=0, idex_flush_o=1, stall_cnt_o 0→1. Repeat with ex_rd_i=0 → no stall.
- **rt dependency:** ex_rd_i=7=id_rt_i with id_uses_rt_i=0 → no stall; with id_uses_rt_i=1 → one-cycle stall.
- **Branch flush:**
  - branch_taken_i pulse → ifid_flush_o=idex_flush_o=1 and all enables 1; flush_cnt_o=1.
  - Load-use condition on the following cycle → suppressed (no stall).
- **Freeze and timeout:**
  - mem_busy_i high for 3 cycles → all enables 0 for 3 cycles, stall_cnt_o=3, mem_timeout_o=0.
  - Hold high 16 cycles → mem_timeout_o=1 after the 16th edge; it stays 1 after busy drops.
- **Priority:** mem_busy_i=1 and branch_taken_i=1 together → freeze only. When busy drops with branch still high → flush in that cycle.
- **Reset and saturation:**
  - Assert rst mid-freeze → all outputs 0 immediately.
  - With CNT_W=2, 5 stall cycles → stall_cnt_o=3 (saturated).

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard inputs and pipeline buffer controls of the stall controller
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_uses_rt_i;
  logic             ex_mem_read_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             branch_taken_i;
  logic             mem_busy_i;
  logic             pc_en_o;
  logic             ifid_en_o;
  logic             idex_en_o;
  logic             exmem_en_o;
  logic             memwb_en_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;

  // Pipeline side: supplies hazard information, consumes enables/flushes
  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, mem_busy_i,
    input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
           ifid_flush_o, idex_flush_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, mem_busy_i,
    output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
           ifid_flush_o, idex_flush_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch-redirect / memory-freeze control for the 5-stage pipeline
module hazard_stall_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   hz,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
  output logic                 mem_timeout_o
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [REG_W-1:0]  ZERO_REG  = '0;

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              stall_inc, flush_inc;
  logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic              ifid_flush, idex_flush;

  // IF/ID holds a squashed instruction in FLUSH, so it cannot depend on the load
  assign load_use = hz.ex_mem_read_i && (hz.ex_rd_i != ZERO_REG) && (state != FLUSH) &&
                    ((hz.ex_rd_i == hz.id_rs_i) ||
                     (hz.id_uses_rt_i && (hz.ex_rd_i == hz.id_rt_i)));

  always_comb begin
    state_nxt  = RUN;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (hz.mem_busy_i) begin
      state_nxt = MEM_WAIT;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      stall_inc = 1'b1;
    end else if (hz.branch_taken_i) begin
      state_nxt  = FLUSH;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
    end
  end

  // Outputs are forced low for as long as reset is held, independent of the clock
  assign hz.pc_en_o      = rst & pc_en;
  assign hz.ifid_en_o    = rst & ifid_en;
  assign hz.idex_en_o    = rst & idex_en;
  assign hz.exmem_en_o   = rst & exmem_en;
  assign hz.memwb_en_o   = rst & memwb_en;
  assign hz.ifid_flush_o = rst & ifid_flush;
  assign hz.idex_flush_o = rst & idex_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (flush_inc && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end

  // wait_cnt counts busy cycles already completed; the flag rises on the edge closing the TIMEOUT-th
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
    end else if (hz.mem_busy_i) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt >= WAIT_LAST) begin
        mem_timeout_o <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
  localparam logic [6:0] NORM   = 7'b11111_00;
  localparam logic [6:0] BUBBLE = 7'b00111_01;
  localparam logic [6:0] REDIR  = 7'b11111_11;
  localparam logic [6:0] FREEZE = 7'b00000_00;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_timeout;
  logic [1:0]  stall_cnt2, flush_cnt2;
  logic        mem_timeout2;
  logic [6:0]  ctl;
  int          checks;
  int          errors;

  hazard_stall_ctrl_if #(.REG_W(5)) hz ();
  hazard_stall_ctrl_if #(.REG_W(5)) hz2 ();

  hazard_stall_ctrl #(.REG_W(5), .CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .hz(hz),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_timeout_o(mem_timeout)
  );

  hazard_stall_ctrl #(.REG_W(5), .CNT_W(2), .TIMEOUT(16)) dut_sat (
    .clk(clk), .rst(rst), .hz(hz2),
    .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2), .mem_timeout_o(mem_timeout2)
  );

  assign hz2.id_rs_i        = hz.id_rs_i;
  assign hz2.id_rt_i        = hz.id_rt_i;
  assign hz2.id_uses_rt_i   = hz.id_uses_rt_i;
  assign hz2.ex_mem_read_i  = hz.ex_mem_read_i;
  assign hz2.ex_rd_i        = hz.ex_rd_i;
  assign hz2.branch_taken_i = hz.branch_taken_i;
  assign hz2.mem_busy_i     = hz.mem_busy_i;

  assign ctl = {hz.pc_en_o, hz.ifid_en_o, hz.idex_en_o, hz.exmem_en_o, hz.memwb_en_o,
                hz.ifid_flush_o, hz.idex_flush_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs_i        = 5'd0;
    hz.id_rt_i        = 5'd0;
    hz.id_uses_rt_i   = 1'b0;
    hz.ex_mem_read_i  = 1'b0;
    hz.ex_rd_i        = 5'd0;
    hz.branch_taken_i = 1'b0;
    hz.mem_busy_i     = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses_rt);
    hz.ex_mem_read_i = 1'b1;
    hz.ex_rd_i       = rd;
    hz.id_rs_i       = rs;
    hz.id_rt_i       = rt;
    hz.id_uses_rt_i  = uses_rt;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_use(5'd5, 5'd5, 5'd0, 1'b0);
    hz.branch_taken_i = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (ctl !== FREEZE) begin errors++; $display("FAIL reset_ctl ctl=%b exp=%b", ctl, FREEZE); end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_stats stall=%0d flush=%0d to=%b exp=0 0 0", stall_cnt, flush_cnt, mem_timeout);
    end
    step();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== NORM) begin errors++; $display("FAIL reset_release ctl=%b exp=%b", ctl, NORM); end
  endtask

  task automatic test_load_use();
    apply_reset();
    load_use(5'd5, 5'd5, 5'd9, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== BUBBLE) begin errors++; $display("FAIL lu_bubble ctl=%b exp=%b", ctl, BUBBLE); end
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL lu_cnt_before got=%0d exp=0", stall_cnt); end
    step();
    hz.ex_mem_read_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== NORM) begin errors++; $display("FAIL lu_after ctl=%b exp=%b", ctl, NORM); end
    checks++;
    if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt_after got=%0d exp=1", stall_cnt); end
    step();
    load_use(5'd0, 5'd0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== NORM) begin errors++; $display("FAIL lu_r0 ctl=%b exp=%b", ctl, NORM); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_r0_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_rt_dep();
    apply_reset();
    load_use(5'd7, 5'd3, 5'd7, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== NORM) begin errors++; $display("FAIL rt_unused ctl=%b exp=%b", ctl, NORM); end
    step();
    hz.id_uses_rt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== BUBBLE) begin errors++; $display("FAIL rt_used ctl=%b exp=%b", ctl, BUBBLE); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd1) begin errors++; $display("FAIL rt_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_branch();
    apply_reset();
    hz.branch_taken_i = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== REDIR) begin errors++; $display("FAIL br_redirect ctl=%b exp=%b", ctl, REDIR); end
    step();
    hz.branch_taken_i = 1'b0;
    load_use(5'd5, 5'd5, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== NORM) begin errors++; $display("FAIL br_lu_suppressed ctl=%b exp=%b", ctl, NORM); end
    checks++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL br_counts flush=%0d stall=%0d exp=1 0", flush_cnt, stall_cnt);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    hz.branch_taken_i = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (ctl !== REDIR) begin errors++; $display("FAIL b2b_second_redirect ctl=%b exp=%b", ctl, REDIR); end
    step();
    hz.branch_taken_i = 1'b0;
    load_use(5'd4, 5'd1, 5'd4, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== NORM) begin errors++; $display("FAIL b2b_suppressed ctl=%b exp=%b", ctl, NORM); end
    checks++;
    if (flush_cnt !== 32'd2) begin errors++; $display("FAIL b2b_flush_cnt got=%0d exp=2", flush_cnt); end
    step();
    @(negedge clk);
    checks++;
    if (ctl !== BUBBLE) begin errors++; $display("FAIL b2b_flush_one_cycle ctl=%b exp=%b", ctl, BUBBLE); end
    step();
    idle_inputs();
  endtask

  task automatic test_freeze();
    apply_reset();
    hz.mem_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== FREEZE) begin errors++; $display("FAIL frz_cycle%0d ctl=%b exp=%b", i, ctl, FREEZE); end
      step();
    end
    hz.mem_busy_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== NORM) begin errors++; $display("FAIL frz_release ctl=%b exp=%b", ctl, NORM); end
    checks++;
    if (stall_cnt !== 32'd3 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL frz_stats stall=%0d to=%b exp=3 0", stall_cnt, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    hz.mem_busy_i = 1'b1;
    repeat (10) step();
    hz.mem_busy_i = 1'b0;
    step();
    hz.mem_busy_i = 1'b1;
    repeat (10) step();
    @(negedge clk);
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_interrupted got=%b exp=0", mem_timeout); end
    apply_reset();
    hz.mem_busy_i = 1'b1;
    repeat (15) step();
    @(negedge clk);
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_after15 got=%b exp=0", mem_timeout); end
    step();
    @(negedge clk);
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_after16 got=%b exp=1", mem_timeout); end
    checks++;
    if (ctl !== FREEZE) begin errors++; $display("FAIL to_enables ctl=%b exp=%b", ctl, FREEZE); end
    hz.mem_busy_i = 1'b0;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (mem_timeout !== 1'b1 || ctl !== NORM || stall_cnt !== 32'd16) begin
      errors++; $display("FAIL to_sticky to=%b ctl=%b stall=%0d exp=1 %b 16", mem_timeout, ctl, NORM, stall_cnt);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    hz.mem_busy_i     = 1'b1;
    hz.branch_taken_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== FREEZE) begin errors++; $display("FAIL pri_freeze%0d ctl=%b exp=%b", i, ctl, FREEZE); end
      step();
    end
    hz.mem_busy_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== REDIR) begin errors++; $display("FAIL pri_redirect ctl=%b exp=%b", ctl, REDIR); end
    checks++;
    if (flush_cnt !== 32'd0 || stall_cnt !== 32'd2) begin
      errors++; $display("FAIL pri_counts_mid flush=%0d stall=%0d exp=0 2", flush_cnt, stall_cnt);
    end
    step();
    hz.branch_taken_i = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_cnt !== 32'd1) begin errors++; $display("FAIL pri_flush_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    hz.mem_busy_i     = 1'b1;
    hz.branch_taken_i = 1'b0;
    repeat (3) step();
    hz.mem_busy_i = 1'b0;
    hz.branch_taken_i = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== FREEZE || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL midrst ctl=%b stall=%0d flush=%0d to=%b exp=all zero", ctl, stall_cnt, flush_cnt, mem_timeout);
    end
    step();
    idle_inputs();
    load_use(5'd6, 5'd6, 5'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== BUBBLE) begin errors++; $display("FAIL midrst_state_run ctl=%b exp=%b", ctl, BUBBLE); end
    step();
    idle_inputs();
  endtask

  task automatic test_saturation();
    apply_reset();
    hz.mem_busy_i = 1'b1;
    repeat (5) step();
    hz.mem_busy_i = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_stall2 got=%0d exp=3", stall_cnt2); end
    checks++;
    if (stall_cnt !== 32'd5) begin errors++; $display("FAIL sat_stall32 got=%0d exp=5", stall_cnt); end
    hz.branch_taken_i = 1'b1;
    repeat (4) step();
    hz.branch_taken_i = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_cnt2 !== 2'd3 || flush_cnt !== 32'd4) begin
      errors++; $display("FAIL sat_flush got=%0d/%0d exp=3/4", flush_cnt2, flush_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_rt_dep();
    test_branch();
    test_back_to_back();
    test_freeze();
    test_timeout();
    test_priority();
    test_mid_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
